// File: rtl/mem_stage_sb.sv
// Purpose: MEM stage with a store buffer in front of a single req/ack data-memory port.
// Latency: stores complete in 0 cycles when an entry is free; loads take >= 2 cycles (issue, then ack).
// Backpressure: ready = 0 holds the MEM instruction while the buffer is full, a load hazard drains, or a read is outstanding.
module mem_stage_sb #(
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        dest_reg,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [31:0]       store_data,
    output logic [4:0]        dest_reg_out,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [ADDR_W-1:0] wb_alu_out,
    output logic [31:0]       load_data,
    output logic              ready,
    output logic              sb_empty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    // One buffered store: word address plus lane-placed data and byte enables
    typedef struct packed {
        logic [WA_W-1:0] waddr;
        logic [31:0]     wdat;
        logic [3:0]      be;
    } sb_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    sb_entry_t            sb_mem [SB_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic                 is_store;
    logic                 is_load;
    logic [WA_W-1:0]      ld_waddr;
    logic                 sb_full;
    logic                 sb_nonempty;
    logic [SB_DEPTH-1:0]  entry_vld;
    logic                 hazard;
    logic [3:0]           lane_be;
    logic [31:0]          lane_dat;
    logic [31:0]          ld_ext;
    logic                 issue_load;
    logic                 issue_drain;
    logic                 push;
    logic                 pop;
    logic                 ld_done;
    sb_entry_t            head;
    sb_entry_t            new_entry;

    // Writeback control passes straight through to the MEM/WB register
    assign dest_reg_out   = dest_reg;
    assign reg_write_out  = reg_write;
    assign mem_to_reg_out = mem_to_reg;
    assign wb_alu_out     = alu_out;

    // A store wins if both flags are set; mem_to_reg alone marks a load
    assign is_store    = mem_write;
    assign is_load     = mem_to_reg & ~mem_write;
    assign ld_waddr    = alu_out[ADDR_W-1:2];
    assign sb_full     = (count == CNT_W'(SB_DEPTH));
    assign sb_nonempty = (count != '0);
    assign head        = sb_mem[rd_ptr];

    // The in-flight store stays in the buffer until its ack pops it
    assign sb_empty    = (count == '0) && (state != S_DRAIN);

    // Load hazard: any live entry (including the in-flight head) hitting the load's word
    always_comb begin
        entry_vld = '0;
        hazard    = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            entry_vld[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
            if (entry_vld[i] && (sb_mem[i].waddr == ld_waddr)) begin
                hazard = is_load;
            end
        end
    end

    // Lane placement for stores (and the lane mask presented with reads)
    always_comb begin
        lane_be  = 4'b1111;
        lane_dat = store_data;
        case (size)
            2'b00: begin
                lane_be  = 4'b0001 << alu_out[1:0];
                lane_dat = {4{store_data[7:0]}};
            end
            2'b01: begin
                lane_be  = alu_out[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{store_data[15:0]}};
            end
            default: begin
                lane_be  = 4'b1111;
                lane_dat = store_data;
            end
        endcase
    end

    assign new_entry = '{waddr: ld_waddr, wdat: lane_dat, be: lane_be};

    // Load result extraction: pick the addressed lane(s) and zero-extend
    always_comb begin
        ld_ext = mem_rdata;
        case (size)
            2'b00: begin
                case (alu_out[1:0])
                    2'd0:    ld_ext = {24'd0, mem_rdata[7:0]};
                    2'd1:    ld_ext = {24'd0, mem_rdata[15:8]};
                    2'd2:    ld_ext = {24'd0, mem_rdata[23:16]};
                    default: ld_ext = {24'd0, mem_rdata[31:24]};
                endcase
            end
            2'b01:   ld_ext = alu_out[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a clean load beats draining; otherwise drain whenever entries exist
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (is_load && !hazard) begin
                    state_nxt = S_LOAD;
                end else if (sb_nonempty) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (mem_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: issue strobes, buffer push/pop, pipeline handshake and load result
    always_comb begin
        issue_load  = rst && (state == S_IDLE) && is_load && !hazard;
        issue_drain = rst && (state == S_IDLE) && !(is_load && !hazard) && sb_nonempty;
        push        = rst && is_store && !sb_full;
        pop         = rst && (state == S_DRAIN) && mem_ack;
        ld_done     = rst && (state == S_LOAD) && mem_ack;
        ready       = 1'b0;
        if (rst) begin
            if (is_store) begin
                ready = !sb_full;
            end else if (is_load) begin
                ready = ld_done;
            end else begin
                ready = 1'b1;
            end
        end
        load_data = ld_done ? ld_ext : 32'd0;
    end

    // Buffer pointers and occupancy; a late ack outside DRAIN never pops
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Store payload array; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            sb_mem[wr_ptr] <= new_entry;
        end
    end

    // Registered memory port: request held until ack, dropped on the ack edge or at reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (issue_load) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {ld_waddr, 2'b00};
            mem_wdata <= '0;
            mem_be    <= lane_be;
        end else if (issue_drain) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {head.waddr, 2'b00};
            mem_wdata <= head.wdat;
            mem_be    <= head.be;
        end else if (mem_ack && (state != S_IDLE)) begin
            mem_req   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Purpose: directed self-checking bench for mem_stage_sb with a simple req/ack memory responder.
// Latency: responder acks a request ack_delay cycles after it first sees mem_req.
// Backpressure: stimulus holds each MEM instruction until ready, counting stall cycles.
module tb_mem_stage_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [1:0]  size;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [4:0]  dest_reg_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic [31:0] wb_alu_out;
    logic [31:0] load_data;
    logic        ready;
    logic        sb_empty;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    mem_stage_sb #(.ADDR_W(32), .SB_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .dest_reg       (dest_reg),
        .reg_write      (reg_write),
        .mem_to_reg     (mem_to_reg),
        .mem_write      (mem_write),
        .size           (size),
        .alu_out        (alu_out),
        .store_data     (store_data),
        .dest_reg_out   (dest_reg_out),
        .reg_write_out  (reg_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .wb_alu_out     (wb_alu_out),
        .load_data      (load_data),
        .ready          (ready),
        .sb_empty       (sb_empty),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Responder state and transaction log
    int          ack_delay = 1;
    int          req_age   = 0;
    int          n_reads   = 0;
    logic [31:0] rd_value  = 32'd0;
    logic        log_we[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_be[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_addr(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] get_wdata(input int i);
        return (i < log_wdata.size()) ? log_wdata[i] : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] get_be(input int i);
        return (i < log_be.size()) ? {28'd0, log_be[i]} : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] get_we(input int i);
        return (i < log_we.size()) ? {31'd0, log_we[i]} : 32'hxxxxxxxx;
    endfunction

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_wdata.delete();
        log_be.delete();
        n_reads = 0;
    endtask

    // One clock: step past the edge, run the memory responder, let comb logic settle
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_ack) begin
            mem_ack = 1'b0;
            req_age = 0;
        end else if (mem_req) begin
            req_age++;
            if (req_age > ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_value;
                log_we.push_back(mem_we);
                log_addr.push_back(mem_addr);
                log_wdata.push_back(mem_wdata);
                log_be.push_back(mem_be);
                if (!mem_we) n_reads++;
            end
        end else begin
            req_age = 0;
        end
        #1;
    endtask

    task automatic nop();
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            output int stall);
        mem_write  = 1'b1;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_out    = a;
        store_data = d;
        size       = sz;
        #1;
        stall = 0;
        while (!ready && stall < 300) begin
            tick();
            stall++;
        end
        tick();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] rdv,
                           output logic [31:0] ld, output int stall);
        rd_value   = rdv;
        mem_write  = 1'b0;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        alu_out    = a;
        size       = sz;
        #1;
        stall = 0;
        while (!ready && stall < 300) begin
            tick();
            stall++;
        end
        ld = load_data;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(sb_empty && !mem_req) && n < 300) begin
            tick();
            n++;
        end
        check(tag, {31'd0, sb_empty & ~mem_req}, 32'd1);
    endtask

    initial begin
        int          st;
        logic [31:0] ld;

        rst        = 1'b0;
        dest_reg   = 5'd0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        size       = 2'b10;
        alu_out    = 32'd0;
        store_data = 32'd0;
        mem_rdata  = 32'd0;
        mem_ack    = 1'b0;

        // Reset behaviour
        tick();
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        tick();
        check("rst_ready2", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        tick();
        tick();
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_req", {31'd0, mem_req}, 32'd0);
        check("idle_sb_empty", {31'd0, sb_empty}, 32'd1);

        // Word, byte and halfword stores drain in order with the right lanes
        ack_delay = 1;
        clear_log();
        do_store(32'h100, 32'hDEADBEEF, 2'b10, st);
        check("t2_stall_w", st, 0);
        do_store(32'h103, 32'h0000005A, 2'b00, st);
        check("t2_stall_b", st, 0);
        do_store(32'h106, 32'h0000BEEF, 2'b01, st);
        check("t2_stall_h", st, 0);
        nop();
        wait_idle("t2_idle");
        check("t2_n", log_addr.size(), 3);
        check("t2_a0", get_addr(0), 32'h100);
        check("t2_d0", get_wdata(0), 32'hDEADBEEF);
        check("t2_be0", get_be(0), 32'hF);
        check("t2_we0", get_we(0), 32'd1);
        check("t2_a1", get_addr(1), 32'h100);
        check("t2_d1", get_wdata(1), 32'h5A5A5A5A);
        check("t2_be1", get_be(1), 32'h8);
        check("t2_a2", get_addr(2), 32'h104);
        check("t2_d2", get_wdata(2), 32'hBEEFBEEF);
        check("t2_be2", get_be(2), 32'hC);

        // Buffer full: fifth store waits for the first pop
        ack_delay = 5;
        clear_log();
        for (int i = 0; i < 5; i++) begin
            do_store(32'h1000 + 32'(i) * 32'h10, 32'hA0 + 32'(i), 2'b10, st);
            check($sformatf("t3_stall%0d", i), st, (i == 4) ? 4 : 0);
        end
        nop();
        wait_idle("t3_idle");
        check("t3_n", log_addr.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_a%0d", i), get_addr(i), 32'h1000 + 32'(i) * 32'h10);
            check($sformatf("t3_d%0d", i), get_wdata(i), 32'hA0 + 32'(i));
        end

        // Load hitting a buffered store waits for the drain
        ack_delay = 1;
        clear_log();
        do_store(32'h200, 32'hCAFEF00D, 2'b10, st);
        do_load(32'h202, 2'b01, 32'h12345678, ld, st);
        check("t4_ld", ld, 32'h00001234);
        check("t4_stall", st, 5);
        tick();
        nop();
        wait_idle("t4_idle");
        check("t4_reads", n_reads, 1);
        check("t4_we0", get_we(0), 32'd1);
        check("t4_a0", get_addr(0), 32'h200);
        check("t4_we1", get_we(1), 32'd0);
        check("t4_a1", get_addr(1), 32'h200);

        // Clean load bypasses a buffered store; pass-through checked too
        clear_log();
        do_store(32'h300, 32'h01020304, 2'b10, st);
        dest_reg = 5'd9;
        do_load(32'h401, 2'b00, 32'hAABBCCDD, ld, st);
        check("t5_ld", ld, 32'h000000CC);
        check("t5_stall", st, 2);
        check("t5_dest", {27'd0, dest_reg_out}, 32'd9);
        check("t5_alu", wb_alu_out, 32'h401);
        check("t5_m2r", {31'd0, mem_to_reg_out}, 32'd1);
        check("t5_rw", {31'd0, reg_write_out}, 32'd1);
        tick();
        nop();
        wait_idle("t5_idle");
        check("t5_we0", get_we(0), 32'd0);
        check("t5_a0", get_addr(0), 32'h400);
        check("t5_be0", get_be(0), 32'h2);
        check("t5_we1", get_we(1), 32'd1);
        check("t5_a1", get_addr(1), 32'h300);

        // Word load (size 11) and top-lane byte load
        clear_log();
        do_load(32'h800, 2'b11, 32'h87654321, ld, st);
        check("t7_ldw", ld, 32'h87654321);
        tick();
        do_load(32'h803, 2'b00, 32'h87654321, ld, st);
        check("t7_ldb", ld, 32'h00000087);
        tick();
        nop();

        // Reset while a drain is pending with two entries buffered
        ack_delay = 50;
        clear_log();
        do_store(32'h500, 32'h55555555, 2'b10, st);
        do_store(32'h504, 32'h66666666, 2'b10, st);
        nop();
        begin
            int n = 0;
            while (!mem_req && n < 20) begin
                tick();
                n++;
            end
        end
        check("t6_pending", {31'd0, mem_req}, 32'd1);
        check("t6_busy", {31'd0, sb_empty}, 32'd0);
        rst = 1'b0;
        #1;
        check("t6_ready_rst", {31'd0, ready}, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("t6_req", {31'd0, mem_req}, 32'd0);
        check("t6_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("t6_addr", mem_addr, 32'd0);
        check("t6_be", {28'd0, mem_be}, 32'd0);
        check("t6_wdata", mem_wdata, 32'd0);
        mem_ack = 1'b1;
        tick();
        check("t6_late_req", {31'd0, mem_req}, 32'd0);
        check("t6_late_empty", {31'd0, sb_empty}, 32'd1);
        check("t6_late_ready", {31'd0, ready}, 32'd1);
        ack_delay = 1;
        clear_log();
        do_store(32'h600, 32'h11223344, 2'b10, st);
        check("t6_stall", st, 0);
        nop();
        wait_idle("t6_idle");
        check("t6_n", log_addr.size(), 1);
        check("t6_a0", get_addr(0), 32'h600);
        check("t6_d0", get_wdata(0), 32'h11223344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_sb.md
# mem_stage_sb

Parametrised memory stage for the five-stage pipeline: it passes writeback control through, and it decouples stores from the memory port with a SB_DEPTH-entry store buffer (FIFO). It also supports byte, halfword and word accesses through byte enables, and it stalls the pipeline through a ready handshake. It sits between the EX/MEM and MEM/WB pipeline registers and owns the single request/acknowledge port to the data memory or cache.

## Interface
- ADDR_W, 32, address width; word addresses use bits [ADDR_W-1:2]
- SB_DEPTH, 4, store-buffer entries (power of two, at least 2)
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-low reset
- dest_reg / reg_write / mem_to_reg  in  5/1/1  writeback control; also acts as the load-request flag
- mem_write  in  1  store request
- size  in  2  access size: 00 byte, 01 halfword, 10 word (11 treated as word)
- alu_out  in  ADDR_W  effective address, passed through to WB
- store_data  in  32  store data, right-aligned
- dest_reg_out / reg_write_out / mem_to_reg_out / wb_alu_out  out  5/1/1/ADDR_W  combinational pass-through
- load_data  out  32  zero-extended load result
- ready  out  1  1 = the instruction in MEM completes this cycle; 0 = pipeline holds MEM inputs stable
- sb_empty  out  1  store buffer empty, with no store in flight
- mem_req / mem_we  out  1/1  memory request, held until acknowledged; write flag
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_wdata / mem_be  out  32/4  lane-placed write data and byte enables
- mem_rdata / mem_ack  in  32/1  read data, valid with mem_ack; 1-cycle acknowledge

## Operation
- Store lane placement:
  - byte: be = 1 << addr[1:0]; the byte is replicated on all lanes.
  - half: be = addr[1] ? 1100 : 0011; the half is replicated; addr[0] is ignored.
  - word: be = 1111.
- FSM states: IDLE, DRAIN (head store in flight), LOAD (load in flight).
- Store in MEM:
  - If count < SB_DEPTH, push {word addr, wdata, be} and assert ready the same cycle.
  - Otherwise ready = 0 until count drops.
- Load hazard: any valid buffer entry, or an in-flight store, whose word address matches the load's word address.
- Load in MEM, FSM in IDLE:
  - No hazard: issue the read (mem_we = 0), go to LOAD. The load has priority over draining.
  - Hazard: drain instead. ready = 0 until the hazard clears.
- In LOAD, on mem_ack: ready = 1 that cycle and load_data is taken from mem_rdata.
  - byte: zero-extended lane addr[1:0].
  - half: zero-extended lanes by addr[1].
  - word: all lanes.
  - FSM returns to IDLE.
- Drain: in IDLE with the buffer non-empty and no hazard-free load pending, issue the head entry (mem_we = 1) and go to DRAIN. On mem_ack, pop and return to IDLE.
- Neither load nor store: ready = 1. Draining continues in the background.
- Stalled load: holds ready = 0 and does not reissue. Exactly one read request is made per load instruction.

## Timing
- Reset (rst = 0 at an edge):
  - State IDLE, count 0, read/write pointers 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0.
  - load_data = 0, sb_empty = 1, ready forced 0 while rst = 0.
- Memory-port outputs are registered. mem_req rises the cycle after the FSM leaves IDLE.
- mem_ack is valid no earlier than 1 cycle after mem_req. mem_req drops the cycle after ack.
- Load latency: minimum 2 cycles from a load reaching MEM (FSM idle, no hazard) to ready = 1.
- Store with a free entry: 0 cycles of stall.
- count is updated on push and pop. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo SB_DEPTH.
- Full condition:
  - A store in MEM while count = SB_DEPTH stalls even if a pop occurs that cycle.
  - It is accepted on the first cycle the registered count < SB_DEPTH.
- ready and the pass-through outputs are combinational from the inputs and state. load_data is valid only when ready = 1 for a load.
- Reset mid-transaction:
  - An outstanding request is abandoned and mem_req drops at the reset edge.
  - Buffered stores are discarded.
  - A late mem_ack arriving in IDLE is ignored.

## Test plan
- Reset, then idle for 2 cycles:
  - Required: mem_req = 0, sb_empty = 1, ready = 0 during reset and 1 after.
- Store word 0xDEADBEEF to 0x100, then store byte 0x5A to 0x103:
  - Both get ready = 1 with 0 stall.
  - Drains in order: be 1111 with 0xDEADBEEF, then be 1000 with 0x5A5A5A5A, both at addr 0x100.
- Five back-to-back stores to distinct addresses, SB_DEPTH = 4, mem_ack delayed 5 cycles:
  - The fifth store sees ready = 0 until the first ack's pop.
  - Total drains = 5, in order.
- Store to 0x200, then an immediate halfword load from 0x202:
  - The load stalls until that store's ack.
  - Exactly one read is issued to 0x200.
  - With mem_rdata = 0x12345678, load_data = 0x00001234.
- Buffered store to 0x300, then a byte load from 0x401, mem_rdata = 0xAABBCCDD:
  - The read is issued before the drain.
  - load_data = 0x000000CC.
- rst low for 1 cycle while a DRAIN request is pending with 2 entries buffered:
  - mem_req = 0 next cycle and sb_empty = 1.
  - A late mem_ack produces no pop and no state change.
